// File: rtl/button_event_decoder_pkg.sv
// Shared types and constants for the button event decoder.
// Optional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
package button_event_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DOWN,
      LONG,
      WAIT,
      DOWN2
   } btn_state_e;

   localparam int LONG_CYCLES_MIN   = 2;
   localparam int DCLICK_CYCLES_MIN = 1;
   localparam int REPEAT_CYCLES_MIN = 1;

   // One counter serves every timed state, so size it for the longest interval.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/button_event_decoder_edge.sv
// Registers the debounced level and flags rising/falling edges.
// btn_q resets high so a button held through reset produces no edge.
module btn_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_level,
   output logic rise,
   output logic fall
);

   logic btn_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) btn_q <= 1'b1;
      else        btn_q <= btn_level;
   end

   assign rise = btn_level & ~btn_q;
   assign fall = ~btn_level & btn_q;

endmodule

// File: rtl/button_event_decoder.sv
// Turns the debounced button level into one-cycle press/release/long/double-click
// pulses; BTN_AUTOREPEAT_EN adds periodic repeat pulses while held in LONG.
module button_event_decoder
   import button_event_pkg::*;
#(
   parameter int LONG_CYCLES   = 50_000_000,
   parameter int DCLICK_CYCLES = 12_500_000,
   parameter int REPEAT_CYCLES = 5_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic dclick_pulse,
   output logic repeat_pulse,
   output logic held
);

   localparam int CNT_W = cnt_width(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES);
   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);

   if (LONG_CYCLES < LONG_CYCLES_MIN) begin : g_long_chk
      $error("LONG_CYCLES below minimum");
   end
   if (DCLICK_CYCLES < DCLICK_CYCLES_MIN) begin : g_dclick_chk
      $error("DCLICK_CYCLES below minimum");
   end
   if (REPEAT_CYCLES < REPEAT_CYCLES_MIN) begin : g_repeat_chk
      $error("REPEAT_CYCLES below minimum");
   end

   logic rise, fall;

   btn_edge_detect u_edge (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_level (btn_level),
      .rise      (rise),
      .fall      (fall)
   );

   btn_state_e       state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             cnt_clr;
   logic             press_nxt, rel_nxt, long_nxt, dclick_nxt;
`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
   logic             rep_nxt;
`endif

   always_comb begin
      state_nxt  = state;
      press_nxt  = 1'b0;
      rel_nxt    = 1'b0;
      long_nxt   = 1'b0;
      dclick_nxt = 1'b0;
      cnt_clr    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_nxt    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (rise) begin
               state_nxt = DOWN;
               press_nxt = 1'b1;
            end
         end
         // A fall on the threshold edge wins: the press stays short.
         DOWN, DOWN2: begin
            if (fall) begin
               state_nxt = (state == DOWN) ? WAIT : IDLE;
               rel_nxt   = 1'b1;
            end else if (cnt == LONG_LAST) begin
               state_nxt = LONG;
               long_nxt  = 1'b1;
            end
         end
         LONG: begin
            if (fall) begin
               state_nxt = IDLE;
               rel_nxt   = 1'b1;
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (cnt == REPEAT_LAST) begin
               rep_nxt = 1'b1;
               cnt_clr = 1'b1;
            end
`endif
         end
         // A rise on the timeout edge still counts as the second click.
         WAIT: begin
            if (rise) begin
               state_nxt  = DOWN2;
               press_nxt  = 1'b1;
               dclick_nxt = 1'b1;
            end else if (cnt == DCLICK_LAST) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) cnt_clr = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         dclick_pulse  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (cnt_clr)         cnt <= '0;
         else if (cnt != '1)  cnt <= cnt + CNT_W'(1);
         press_pulse   <= press_nxt;
         release_pulse <= rel_nxt;
         long_pulse    <= long_nxt;
         dclick_pulse  <= dclick_nxt;
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) repeat_pulse <= 1'b0;
      else        repeat_pulse <= rep_nxt;
   end
`else
   assign repeat_pulse = 1'b0;
`endif

   assign held = (state == DOWN) || (state == LONG) || (state == DOWN2);

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench: an event/timestamp model is checked against the DUT every cycle,
// and per-scenario pulse counts and latencies are pinned to hand-derived literals.
module tb_button_event_decoder;

   localparam int LC = 8;
   localparam int DC = 4;
   localparam int RC = 3;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_level = 1'b0;
   logic press_pulse, release_pulse, long_pulse, dclick_pulse, repeat_pulse, held;

   button_event_decoder #(
      .LONG_CYCLES   (LC),
      .DCLICK_CYCLES (DC),
      .REPEAT_CYCLES (RC)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .dclick_pulse  (dclick_pulse),
      .repeat_pulse  (repeat_pulse),
      .held          (held)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Model: timestamps of the current press / last short release, no state encoding.
   int  e = 0;
   bit  m_prev = 1'b1;
   bit  m_held, m_long, m_second, m_win;
   int  m_press_e, m_rel_e, m_rise_e;
   bit  x_press, x_rel, x_long, x_dclick, x_rep;

   // DUT observations for the literal checks.
   int  n_press, n_rel, n_long, n_dclick, n_rep, n_both;
   int  d_long_e, d_rep1_e, d_press_e, d_rel_e;

   task automatic clr_counts();
      n_press = 0; n_rel = 0; n_long = 0; n_dclick = 0; n_rep = 0; n_both = 0;
      d_long_e = -1; d_rep1_e = -1; d_press_e = -1; d_rel_e = -1;
   endtask

   initial begin
      bit lvl, rise, fall;
      forever begin
         @(posedge clk);
         e++;
         if (!rst_n) begin
            m_prev = 1'b1; m_held = 0; m_long = 0; m_second = 0; m_win = 0;
         end else begin
            lvl  = btn_level;
            rise = lvl && !m_prev;
            fall = !lvl && m_prev;
            m_prev = lvl;
            x_press = 0; x_rel = 0; x_long = 0; x_dclick = 0; x_rep = 0;
            if (m_held) begin
               if (fall) begin
                  x_rel   = 1;
                  m_held  = 0;
                  m_win   = !m_long && !m_second;
                  m_rel_e = e;
               end else if (!m_long) begin
                  if (e - m_press_e == LC) begin
                     x_long = 1;
                     m_long = 1;
                  end
               end else if (REP_EN && ((e - m_press_e - LC) % RC == 0)) begin
                  x_rep = 1;
               end
            end else if (rise) begin
               x_press   = 1;
               x_dclick  = m_win && (e - m_rel_e <= DC);
               m_second  = x_dclick;
               m_held    = 1;
               m_long    = 0;
               m_win     = 0;
               m_press_e = e;
               m_rise_e  = e;
            end
            @(negedge clk);
            if (rst_n) begin
               chk("press_pulse", int'(press_pulse), int'(x_press));
               chk("release_pulse", int'(release_pulse), int'(x_rel));
               chk("long_pulse", int'(long_pulse), int'(x_long));
               chk("dclick_pulse", int'(dclick_pulse), int'(x_dclick));
               chk("repeat_pulse", int'(repeat_pulse), int'(x_rep));
               chk("held", int'(held), int'(m_held));
               if (press_pulse) begin n_press++; d_press_e = e; end
               if (release_pulse) begin n_rel++; d_rel_e = e; end
               if (long_pulse) begin n_long++; d_long_e = e; end
               if (dclick_pulse) n_dclick++;
               if (dclick_pulse && press_pulse) n_both++;
               if (repeat_pulse) begin
                  if (n_rep == 0) d_rep1_e = e;
                  n_rep++;
               end
            end
         end
      end
   end

   // Each call drives lvl for n consecutive sampled edges.
   task automatic hold(input bit lvl, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         btn_level = lvl;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      int rise_e;
      clr_counts();
      repeat (3) @(negedge clk);
      chk("reset_press", int'(press_pulse), 0);
      chk("reset_release", int'(release_pulse), 0);
      chk("reset_long", int'(long_pulse), 0);
      chk("reset_dclick", int'(dclick_pulse), 0);
      chk("reset_repeat", int'(repeat_pulse), 0);
      chk("reset_held", int'(held), 0);
      rst_n = 1'b1;
      hold(0, 3);

      // Short press
      clr_counts();
      hold(1, 3);
      hold(0, 10);
      settle();
      chk("short_press_cnt", n_press, 1);
      chk("short_rel_cnt", n_rel, 1);
      chk("short_long_cnt", n_long, 0);
      chk("short_dclick_cnt", n_dclick, 0);
      chk("short_rel_latency", d_rel_e - d_press_e, 3);

      // Long press with repeats, then a quick re-press that is not a double click
      clr_counts();
      hold(1, 21);
      rise_e = m_rise_e;
      hold(0, 2);
      hold(1, 2);
      hold(0, 8);
      settle();
      chk("long_cnt", n_long, 1);
      chk("long_latency", d_long_e - rise_e, 8);
      chk("long_rep_cnt", n_rep, REP_EN ? 4 : 0);
      if (REP_EN) chk("long_rep1_latency", d_rep1_e - rise_e, 11);
      chk("long_press_cnt", n_press, 2);
      chk("long_rel_cnt", n_rel, 2);
      chk("long_no_dclick", n_dclick, 0);

      // Fall on the threshold edge
      clr_counts();
      hold(1, 8);
      hold(0, 10);
      settle();
      chk("bnd_long_cnt", n_long, 0);
      chk("bnd_rel_cnt", n_rel, 1);

      // Double click at the window edge, then a third press
      clr_counts();
      hold(1, 2);
      hold(0, 4);
      hold(1, 2);
      hold(0, 4);
      hold(1, 2);
      hold(0, 10);
      settle();
      chk("dc4_press_cnt", n_press, 3);
      chk("dc4_dclick_cnt", n_dclick, 1);
      chk("dc4_both_cnt", n_both, 1);
      chk("dc4_rel_cnt", n_rel, 3);

      // Second rise one edge past the window
      clr_counts();
      hold(1, 2);
      hold(0, 5);
      hold(1, 2);
      hold(0, 10);
      settle();
      chk("dc5_press_cnt", n_press, 2);
      chk("dc5_dclick_cnt", n_dclick, 0);

      // Reset mid-DOWN with the button held across deassertion
      hold(1, 3);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_held", int'(held), 0);
      chk("rst_async_press", int'(press_pulse), 0);
      chk("rst_async_release", int'(release_pulse), 0);
      chk("rst_async_long", int'(long_pulse), 0);
      repeat (3) @(negedge clk);
      clr_counts();
      rst_n = 1'b1;
      hold(1, 5);
      hold(0, 5);
      settle();
      chk("rst_held_press_cnt", n_press, 0);
      chk("rst_held_rel_cnt", n_rel, 0);
      hold(1, 2);
      hold(0, 6);
      settle();
      chk("rst_new_press_cnt", n_press, 1);
      chk("rst_new_rel_cnt", n_rel, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
